// File: rtl/norm_sequencer.sv
// norm_sequencer: control FSM for the normalization phase of the FP adder.
// Drives the shift-register datapath until its leading bit is set, tracks
// the matching exponent adjustment and raises zero/overflow/underflow flags.
module norm_sequencer #(
  parameter int W_Sgf = 23,
  parameter int W_Exp = 8,
  parameter int W_Cnt = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W_Exp-1:0] Exp_in,
  input  logic             Sgf_ncarry,
  input  logic             Sgf_nbit,
  output logic             selector,
  output logic             ctrl_b,
  output logic             ctrl_c,
  output logic             shift_left,
  output logic             shift_right,
  output logic             shift_in,
  output logic [W_Exp-1:0] Exp_out,
  output logic             zero_flag,
  output logic             overflow,
  output logic             underflow,
  output logic             busy,
  output logic             ready
);

  // A significand still unnormalized after this many left shifts is zero.
  localparam logic [W_Cnt-1:0] CNT_LIMIT = W_Cnt'(W_Sgf + 2);
  localparam logic [W_Exp-1:0] EXP_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_SHR,
    S_SHL,
    S_STORE,
    S_ZERO,
    S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [W_Exp-1:0] exp_reg;
  logic [W_Cnt-1:0] cnt_reg;
  logic             zero_reg, ovf_reg, unf_reg;
  logic [W_Exp-1:0] exp_inc;

  // Saturating increment: the exponent never wraps past all ones.
  assign exp_inc = (exp_reg == EXP_MAX) ? EXP_MAX : exp_reg + W_Exp'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state decision; CHECK resolves carry, leading bit, exponent floor
  // and zero detection in that priority.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_LOAD;
      S_LOAD:  state_next = S_CHECK;
      S_CHECK: begin
        if (Sgf_ncarry)                state_next = S_SHR;
        else if (Sgf_nbit)             state_next = S_STORE;
        else if (exp_reg == '0)        state_next = S_STORE;
        else if (cnt_reg == CNT_LIMIT) state_next = S_ZERO;
        else                           state_next = S_SHL;
      end
      S_SHR:   state_next = S_CHECK;
      S_SHL:   state_next = S_CHECK;
      S_STORE: state_next = S_DONE;
      S_ZERO:  state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Exponent, shift counter and result flags; these hold after DONE until
  // the next LOAD so the packing phase can read them at leisure.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_reg  <= '0;
      cnt_reg  <= '0;
      zero_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      unf_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_LOAD: begin
          exp_reg  <= Exp_in;
          cnt_reg  <= '0;
          zero_reg <= 1'b0;
          ovf_reg  <= 1'b0;
          unf_reg  <= 1'b0;
        end
        S_CHECK: begin
          if (!Sgf_ncarry && !Sgf_nbit && (exp_reg == '0)) unf_reg <= 1'b1;
        end
        S_SHR: begin
          exp_reg <= exp_inc;
          if (exp_inc == EXP_MAX) ovf_reg <= 1'b1;
        end
        S_SHL: begin
          // CHECK has already ruled out exp==0, so this cannot wrap.
          exp_reg <= exp_reg - W_Exp'(1);
          cnt_reg <= cnt_reg + W_Cnt'(1);
        end
        S_ZERO: begin
          exp_reg  <= '0;
          zero_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Moore command decode from the current state.
  always_comb begin
    selector    = 1'b0;
    ctrl_b      = 1'b0;
    ctrl_c      = 1'b0;
    shift_left  = 1'b0;
    shift_right = 1'b0;
    ready       = 1'b0;
    case (state_reg)
      S_LOAD: begin
        ctrl_b = 1'b1;
      end
      S_SHR: begin
        selector    = 1'b1;
        ctrl_b      = 1'b1;
        shift_right = 1'b1;
      end
      S_SHL: begin
        selector   = 1'b1;
        ctrl_b     = 1'b1;
        shift_left = 1'b1;
      end
      S_STORE: ctrl_c = 1'b1;
      S_ZERO:  ctrl_c = 1'b1;
      S_DONE:  ready  = 1'b1;
      default: ;
    endcase
  end

  assign shift_in  = 1'b0;
  assign busy      = (state_reg != S_IDLE);
  assign Exp_out   = exp_reg;
  assign zero_flag = zero_reg;
  assign overflow  = ovf_reg;
  assign underflow = unf_reg;

endmodule

// File: tb/tb_norm_sequencer.sv
// Testbench for norm_sequencer: pairs it with a behavioural normalization
// datapath and checks each operation against a closed-form reference.
module tb_norm_sequencer;

  localparam int W_Sgf = 23;
  localparam int W_Exp = 8;
  localparam int W_Cnt = 5;
  localparam int W_R   = W_Sgf + 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [W_Exp-1:0] Exp_in = '0;
  logic [W_R-1:0]   Sgf_R = '0;
  logic             Sgf_ncarry, Sgf_nbit;
  logic             selector, ctrl_b, ctrl_c, shift_left, shift_right, shift_in;
  logic [W_Exp-1:0] Exp_out;
  logic             zero_flag, overflow, underflow, busy, ready;

  logic [W_R-1:0]   sgf_q  = '0;
  logic [W_R-1:0]   sgf_nf = '0;

  int vectors     = 0;
  int miscompares = 0;

  norm_sequencer #(.W_Sgf(W_Sgf), .W_Exp(W_Exp), .W_Cnt(W_Cnt)) dut (
    .clk(clk), .rst(rst), .start(start), .Exp_in(Exp_in),
    .Sgf_ncarry(Sgf_ncarry), .Sgf_nbit(Sgf_nbit),
    .selector(selector), .ctrl_b(ctrl_b), .ctrl_c(ctrl_c),
    .shift_left(shift_left), .shift_right(shift_right), .shift_in(shift_in),
    .Exp_out(Exp_out), .zero_flag(zero_flag), .overflow(overflow),
    .underflow(underflow), .busy(busy), .ready(ready)
  );

  always #5 clk = ~clk;

  // Normalization datapath: mux + bidirectional shift register + output reg.
  always @(posedge clk) begin
    if (ctrl_b) begin
      if (shift_left)       sgf_q <= {sgf_q[W_R-2:0], shift_in};
      else if (shift_right) sgf_q <= {shift_in, sgf_q[W_R-1:1]};
      else                  sgf_q <= selector ? sgf_q : Sgf_R;
    end
    if (ctrl_c) sgf_nf <= sgf_q;
  end
  assign Sgf_ncarry = sgf_q[W_R-1];
  assign Sgf_nbit   = sgf_q[W_R-2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Closed-form expectation: position of the leading one decides the shifts.
  task automatic ref_model(input logic [W_R-1:0] s, input int e,
                           output int k_shl, output int k_shr, output int e_out,
                           output bit zf, output bit of, output bit uf,
                           output logic [W_R-1:0] nf, output int lat);
    int msb, need;
    k_shl = 0; k_shr = 0; zf = 0; of = 0; uf = 0;
    if (s[W_R-1]) begin
      k_shr = 1;
      e_out = (e == 255) ? 255 : e + 1;
      of    = (e_out == 255);
      nf    = s >> 1;
      lat   = 6;
    end else begin
      if (s == '0) begin
        if (e > W_Sgf + 2) begin
          k_shl = W_Sgf + 2; zf = 1; e_out = 0;
        end else begin
          k_shl = e; uf = 1; e_out = 0;
        end
        nf = '0;
      end else begin
        msb = 0;
        for (int i = 0; i < W_R; i++) if (s[i]) msb = i;
        need = (W_R - 2) - msb;
        if (need <= e) begin
          k_shl = need; e_out = e - need;
        end else begin
          k_shl = e; uf = 1; e_out = 0;
        end
        nf = s << k_shl;
      end
      lat = 2 * k_shl + 4;
    end
  endtask

  // One operation; glitch>0 pulses start again in that cycle (must be ignored).
  task automatic run_op(input logic [W_R-1:0] s, input logic [W_Exp-1:0] e, input int glitch);
    int k_shl, k_shr, e_out, lat_exp, lat, n_shl, n_shr, n_c;
    bit zf, of, uf, prev_b;
    logic [W_R-1:0] nf;
    ref_model(s, int'(e), k_shl, k_shr, e_out, zf, of, uf, nf, lat_exp);
    @(posedge clk); #1;
    Sgf_R = s; Exp_in = e; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; n_shl = 0; n_shr = 0; n_c = 0; prev_b = 0;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      check("cmd_legal", {28'd0, shift_in, shift_left & shift_right, ctrl_b & prev_b, ~busy}, 32'd0);
      prev_b = ctrl_b;
      if (shift_left)  n_shl++;
      if (shift_right) n_shr++;
      if (ctrl_c)      n_c++;
      if (c == 2) begin Sgf_R = W_R'($urandom); Exp_in = W_Exp'($urandom); end
      start = (c == glitch);
      if (ready) begin lat = c; break; end
    end
    if (lat == 0) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    check("latency",   lat,        lat_exp);
    check("exp_out",   Exp_out,    e_out);
    check("zero_flag", zero_flag,  zf);
    check("overflow",  overflow,   of);
    check("underflow", underflow,  uf);
    check("n_shl",     n_shl,      k_shl);
    check("n_shr",     n_shr,      k_shr);
    check("n_ctrl_c",  n_c,        1);
    check("sgf_nf",    32'(sgf_nf), 32'(nf));
    check("idle_after", {30'd0, busy, ready}, 32'd0);
    $display("op sgf=0x%07h exp=0x%02h -> exp_out=0x%02h z=%0d o=%0d u=%0d lat=%0d",
             s, e, Exp_out, zero_flag, overflow, underflow, lat);
  endtask

  // Abort a zero-significand run with reset in its 5th cycle.
  task automatic reset_mid_op();
    @(posedge clk); #1;
    Sgf_R = '0; Exp_in = 8'h7F; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 5) rst = 1'b1;
      if (c < 5) @(posedge clk);
    end
    @(posedge clk); #1;
    check("rst_outputs", {22'd0, busy, selector, ctrl_b, ctrl_c, shift_left, shift_right, ready,
                          zero_flag, overflow, underflow}, 32'd0);
    check("rst_exp_out", Exp_out, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("rst_quiet", {30'd0, busy, ready}, 32'd0);
    end
    $display("reset mid-operation -> busy=%0d exp_out=0x%02h", busy, Exp_out);
  endtask

  initial begin
    logic [W_R-1:0] one, s;
    logic [W_Exp-1:0] e;
    int lead, g;
    one = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {22'd0, busy, selector, ctrl_b, ctrl_c, shift_left, shift_right, ready,
                          zero_flag, overflow, underflow}, 32'd0);
    check("reset_exp", Exp_out, 32'd0);
    rst = 1'b0;

    run_op(27'h2000000, 8'h80, 0);
    run_op(27'h4000001, 8'h80, 0);
    run_op(27'h0400000, 8'h10, 0);
    run_op(27'h0000000, 8'h7F, 0);
    run_op(27'h4000000, 8'hFE, 0);
    run_op(27'h0400000, 8'h01, 0);
    run_op(27'h4000000, 8'hFF, 0);
    run_op(27'h0000001, 8'h19, 0);
    run_op(27'h0400000, 8'h10, 5);
    run_op(27'h2000000, 8'h80, 4);
    reset_mid_op();
    run_op(27'h0400000, 8'h10, 0);

    for (int n = 0; n < 40; n++) begin
      lead = $urandom_range(0, W_R);
      if (lead == W_R) s = '0;
      else s = (one << lead) | (W_R'($urandom) & ((one << lead) - one));
      case ($urandom_range(0, 3))
        0:       e = W_Exp'($urandom_range(0, 6));
        1:       e = W_Exp'($urandom_range(250, 255));
        default: e = W_Exp'($urandom);
      endcase
      g = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 8) : 0;
      run_op(s, e, g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
